data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting between the CPU load/store path and `data_mem`. It presents the same load/store interface as `data_mem` to the CPU and drives `data_mem`'s ports on the memory side. Load hits return data combinationally in the same cycle. Load misses stall the CPU while a one-word line is refilled from `data_mem`. Stores always pass straight through to memory.

## Interface
- `ADDRESS_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; one line = one word.
- `SET_BITS`, 6: index width; the cache holds 2^SET_BITS lines. Tag width = ADDRESS_WIDTH-2-SET_BITS.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  ADDRESS_WIDTH  CPU byte address (ALU result).
- `we`  in  1  CPU store enable.
- `re`  in  1  CPU load enable.
- `writedata`  in  DATA_WIDTH  CPU store data.
- `memcontrol`  in  3  funct3 of the load/store.
- `readdata`  out  DATA_WIDTH  extended load result.
- `stall`  out  1  CPU must hold all inputs while high.
- `mem_a`  out  ADDRESS_WIDTH  address to `data_mem`.
- `mem_we`  out  1  write enable to `data_mem`.
- `mem_writedata`  out  DATA_WIDTH  store data to `data_mem`.
- `mem_memcontrol`  out  3  access type to `data_mem`.
- `mem_readdata`  in  DATA_WIDTH  asynchronous read data from `data_mem`.

## Operation
- Address split:
  - `a[1:0]` = byte offset.
  - `a[SET_BITS+1:2]` = index.
  - Remaining upper bits = tag.
- Per-line state: valid bit, tag, and a 32-bit word. Valid bits form a flat vector so reset clears them all.
- Hit condition: valid[index] is set and the stored tag equals the address tag.
- Load extraction from the hit word, with half and word accesses aligned down:
  - 000: byte, sign-extended.
  - 100: byte, zero-extended.
  - 001: half, sign-extended.
  - 101: half, zero-extended.
  - 010: word.
  - Any other code: readdata = 32'hdeadbeef, no stall, no refill.
- FSM states:
  - IDLE: memory port passes through CPU signals (mem_a=a, mem_we=we, mem_writedata=writedata, mem_memcontrol=memcontrol).
    - If re=1, we=0, the code is valid and the access misses: stall=1, next state FILL.
    - Otherwise stall=0 and the state stays IDLE.
  - FILL:
    - Drives mem_a={a[ADDRESS_WIDTH-1:2],2'b00}, mem_memcontrol=3'b010, mem_we=0; stall=1.
    - At the clock edge: line[index] ← mem_readdata, tag written, valid set; next state IDLE.
- Store (we=1, any state except FILL):
  - Forwarded to memory in the same cycle.
  - On a hit, the cached word is byte-merged at the edge (byte, half or word lane per memcontrol/offset).
  - On a miss, the cache is left untouched (no allocate).
- we=1 and re=1 together is treated as a store; re is ignored.
- The line-replacement policy is overwrite: a refill evicts whatever occupies the index. No write-back is needed because the cache is write-through.

## Timing
- Reset (any state, including mid-FILL):
  - State → IDLE and all valid bits cleared in one cycle.
  - An abandoned refill writes nothing.
  - Outputs during reset: stall=0, mem_we=0, readdata=32'h0.
- Load hit: 0 extra cycles; readdata is valid combinationally in the issue cycle.
- Load miss:
  - Cycle N: stall=1 (combinational).
  - Cycle N+1: FILL, stall=1.
  - Cycle N+2: hit, stall=0, readdata valid.
  - Miss penalty: 2 cycles.
- Store: 1 cycle, never stalls; memory and the cache line update at the same edge.
- Boundary conditions:
  - Tag mismatch on a valid line counts as a miss.
  - Index wrap: addresses differing only above the index bits alias to the same line.
  - Lines with the highest index and index 0 follow the same rules.
- The CPU holds inputs while stall=1. Input changes during FILL are undefined, except for `rst`.

## Configuration
- `DCACHE_STATS_EN`:
  - Defined: adds outputs `hit_count` and `miss_count` (32-bit each, reset to 0, wrap at 2^32).
    - `hit_count` increments once per load accepted with stall=0 in IDLE.
    - `miss_count` increments once per IDLE→FILL transition.
    - Stores and invalid codes are not counted.
  - Undefined: these ports and counters are absent; the remaining behaviour is identical.

## Test plan
- Reset, then lw at 0x10000 (memory holds 0x80FF1234) → stall=1 for 2 cycles, then readdata=0x80FF1234; the repeat lw hits with stall=0.
- After that fill:
  - lb at 0x10003 → 0xFFFFFF80.
  - lbu at 0x10003 → 0x00000080.
  - lh at 0x10002 → 0xFFFF80FF.
  - lhu at 0x10001 (aligns to 0x10000) → 0x00001234.
- sb 0xAB at 0x10001 on a hit line → mem_we=1 in the same cycle; the next lw at 0x10000 hits and returns 0x80FFAB34. A sw to an uncached address → no stall, and a later lw misses.
- lw at 0x10000, then lw at 0x10000+4·2^SET_BITS (same index, different tag) → both miss. A third lw at 0x10000 misses again (the line was evicted).
- Assert rst during FILL → next cycle: IDLE, stall=0, and the same load misses again. With `DCACHE_STATS_EN`, hit_count and miss_count read 0 after reset.
- Load with memcontrol=3'b011 → readdata=0xDEADBEEF, stall=0, no memory access change.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_BITS      = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] a,
    input  logic                     we,
    input  logic                     re,
    input  logic [DATA_WIDTH-1:0]    writedata,
    input  logic [2:0]               memcontrol,
    output logic [DATA_WIDTH-1:0]    readdata,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_writedata,
    output logic [2:0]               mem_memcontrol,
    input  logic [DATA_WIDTH-1:0]    mem_readdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - 2 - SET_BITS;
    localparam int LINES     = 1 << SET_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, next_state;

    logic [LINES-1:0]      valid;
    logic [TAG_WIDTH-1:0]  tags  [LINES];
    logic [DATA_WIDTH-1:0] lines [LINES];

    logic [SET_BITS-1:0]   index;
    logic [TAG_WIDTH-1:0]  tag;
    logic [1:0]            offset;
    logic [DATA_WIDTH-1:0] word;
    logic                  hit;
    logic                  code_ok;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    assign offset = a[1:0];
    assign index  = a[SET_BITS+1:2];
    assign tag    = a[ADDRESS_WIDTH-1:SET_BITS+2];
    assign word   = lines[index];
    assign hit    = valid[index] && (tags[index] == tag);

    always_comb begin
        code_ok = 1'b0;
        case (memcontrol)
            3'b000, 3'b100, 3'b001, 3'b101, 3'b010: code_ok = 1'b1;
            default:                                code_ok = 1'b0;
        endcase
    end

    // Load lane extraction; halves align down to the even halfword.
    always_comb begin
        load_byte = word[7:0];
        case (offset)
            2'd0: load_byte = word[7:0];
            2'd1: load_byte = word[15:8];
            2'd2: load_byte = word[23:16];
            2'd3: load_byte = word[31:24];
            default: load_byte = word[7:0];
        endcase
        load_half = a[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (memcontrol)
            3'b000:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
            default: load_data = word;
        endcase
    end

    // Byte-merge of a store into the cached word, used only on a store hit.
    always_comb begin
        store_word = word;
        case (memcontrol)
            3'b000: begin
                case (offset)
                    2'd0: store_word[7:0]   = writedata[7:0];
                    2'd1: store_word[15:8]  = writedata[7:0];
                    2'd2: store_word[23:16] = writedata[7:0];
                    2'd3: store_word[31:24] = writedata[7:0];
                    default: store_word = word;
                endcase
            end
            3'b001: begin
                if (a[1]) store_word[31:16] = writedata[15:0];
                else      store_word[15:0]  = writedata[15:0];
            end
            3'b010:  store_word = writedata;
            default: store_word = word;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    always_comb begin
        next_state     = state;
        stall          = 1'b0;
        mem_a          = a;
        mem_we         = we;
        mem_writedata  = writedata;
        mem_memcontrol = memcontrol;
        readdata       = code_ok ? load_data : 32'hdeadbeef;
        case (state)
            IDLE: begin
                if (re && !we && code_ok && !hit) begin
                    stall      = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                mem_a          = {a[ADDRESS_WIDTH-1:2], 2'b00};
                mem_memcontrol = 3'b010;
                mem_we         = 1'b0;
                stall          = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (rst) begin
            stall      = 1'b0;
            mem_we     = 1'b0;
            readdata   = '0;
            next_state = IDLE;
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst)                valid        <= '0;
        else if (state == FILL) valid[index] <= 1'b1;
    end

    // NOTE: tag and data arrays are not reset; the valid vector alone makes stale contents harmless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL) begin
                lines[index] <= mem_readdata;
                tags[index]  <= tag;
            end else if (we && hit) begin
                lines[index] <= store_word;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && re && !we && code_ok) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
